pc_branch_unit: RTL



---
 rtl/pc_branch_pkg.sv | 17 +
 rtl/return_stack.sv | 47 ++++
 rtl/pc_branch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/pc_branch_pkg.sv
// rtl/pc_branch_pkg.sv - branch operation encoding shared by the PC/branch stage
package pc_branch_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_JMP  = 4'd1,
        BR_BEQ  = 4'd2,
        BR_BNE  = 4'd3,
        BR_BGT  = 4'd4,
        BR_BGE  = 4'd5,
        BR_BLT  = 4'd6,
        BR_BLE  = 4'd7,
        BR_CALL = 4'd8,
        BR_RET  = 4'd9
    } branch_op_t;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - LIFO return-address stack with combinational top-of-stack read
module return_stack #(
    parameter int DATA_WIDTH  = 11,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [STACK_DEPTH];
    logic [CNT_W-1:0]      r_count;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;

    assign w_wr_idx = IDX_W'(r_count);
    assign w_rd_idx = IDX_W'(r_count - CNT_W'(1));
    assign full     = (r_count == CNT_W'(STACK_DEPTH));
    assign empty    = (r_count == '0);
    assign data_out = r_mem[w_rd_idx];

    // Entries are never cleared; only the count defines what is valid.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (push && !full) begin
            r_count <= r_count + CNT_W'(1);
        end else if (pop && !empty) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter, branch resolution and call/return handling
module pc_branch_unit
    import pc_branch_pkg::*;
#(
    parameter int DATA_WIDTH  = 11,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  pc_reset,
    input  logic                  pc_enable,
    input  logic [3:0]            branch_op,
    input  logic [DATA_WIDTH-1:0] target_in,
    input  logic                  flag_Z,
    input  logic                  flag_N,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic                  branch_taken,
    output logic                  stack_overflow,
    output logic                  stack_underflow
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_taken;
    logic                  r_ovf;
    logic                  r_unf;

    logic [DATA_WIDTH-1:0] w_pc_inc;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic [DATA_WIDTH-1:0] w_stack_top;
    logic                  w_redirect;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_set_ovf;
    logic                  w_set_unf;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_stack_push;
    logic                  w_stack_pop;

    assign w_pc_inc = r_pc + DATA_WIDTH'(1);

    always_comb begin
        w_redirect = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_set_ovf  = 1'b0;
        w_set_unf  = 1'b0;
        w_next_pc  = w_pc_inc;
        case (branch_op_t'(branch_op))
            BR_JMP:  w_redirect = 1'b1;
            BR_BEQ:  w_redirect = flag_Z;
            BR_BNE:  w_redirect = !flag_Z;
            BR_BGT:  w_redirect = !flag_Z && !flag_N;
            BR_BGE:  w_redirect = !flag_N;
            BR_BLT:  w_redirect = flag_N;
            BR_BLE:  w_redirect = flag_N || flag_Z;
            BR_CALL: begin
                w_redirect = !w_full;
                w_push     = !w_full;
                w_set_ovf  = w_full;
            end
            BR_RET: begin
                w_redirect = !w_empty;
                w_pop      = !w_empty;
                w_set_unf  = w_empty;
            end
            default: ;
        endcase
        // RET is the only redirect whose destination comes from the stack.
        if (w_redirect) begin
            w_next_pc = w_pop ? w_stack_top : target_in;
        end
    end

    assign w_stack_push = pc_enable && w_push;
    assign w_stack_pop  = pc_enable && w_pop;

    return_stack #(
        .DATA_WIDTH  (DATA_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clock    (clock),
        .reset    (pc_reset),
        .push     (w_stack_push),
        .pop      (w_stack_pop),
        .data_in  (w_pc_inc),
        .data_out (w_stack_top),
        .full     (w_full),
        .empty    (w_empty)
    );

    always_ff @(posedge clock) begin
        if (pc_reset) begin
            r_pc    <= '0;
            r_taken <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (pc_enable) begin
            r_pc    <= w_next_pc;
            r_taken <= w_redirect;
            r_ovf   <= r_ovf || w_set_ovf;
            r_unf   <= r_unf || w_set_unf;
        end else begin
            r_taken <= 1'b0;
        end
    end

    assign pc_out          = r_pc;
    assign branch_taken    = r_taken;
    assign stack_overflow  = r_ovf;
    assign stack_underflow = r_unf;

endmodule
